// File: rtl/prog_pkg.sv
// Shared definitions for the program-memory loader: opcode map, load FSM
// encoding and the instruction word layout.
package prog_pkg;

    // Opcode map (upper nibble of an instruction word)
    localparam logic [3:0] OP_NOP       = 4'b0000;
    localparam logic [3:0] OP_ADD       = 4'b0001;
    localparam logic [3:0] OP_SUB       = 4'b0010;
    localparam logic [3:0] OP_OUT       = 4'b0011;
    localparam logic [3:0] OP_IN        = 4'b0100;
    localparam logic [3:0] OP_LOAD      = 4'b0101;
    localparam logic [3:0] OP_MAX_LEGAL = 4'b0101;

    // Load FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HI_HELD = 2'd1,
        FULL    = 2'd2
    } load_state_e;

    // Instruction word: opcode nibble in [7:4], operand nibble in [3:0]
    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] operand;
    } instr_word_t;

    // True when the opcode nibble is part of the defined instruction set
    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_MAX_LEGAL;
    endfunction

endpackage

// File: rtl/prog_mem_array.sv
// DEPTH x DW register array: synchronous write, registered read port that
// holds its last value when not read, synchronous clear of contents and read data.
module prog_mem_array #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          rd_en,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    // Next contents and next read data
    always_comb begin
        mem_d   = mem_q;
        rdata_d = rdata_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
        if (rd_en) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Storage and read register; clear wipes every word back to NOP
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/prog_mem_loader.sv
// Program-memory responder: assembles keyboard nibbles into instruction words
// in load mode and serves 1-cycle-latency fetches in run mode.
// Optional build macro PROG_MEM_OPCODE_CHECK_EN: illegal opcode nibbles are
// stored as NOP and flagged on the sticky bad_op output.
module prog_mem_loader
    import prog_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned DW    = 8
) (
    input  logic          clk1,
    input  logic          MainClear,
    input  logic          load_en,
    input  logic [3:0]    kbd,
    input  logic          kbd_valid,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_valid,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] wr_ptr,
    output logic          load_done,
    output logic          nib_pending
`ifdef PROG_MEM_OPCODE_CHECK_EN
    ,
    output logic          bad_op
`endif
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_HI_HELD = HI_HELD;
    localparam logic [1:0] ST_FULL    = FULL;

    logic [1:0]    state_q, state_d;
    logic [3:0]    hi_q, hi_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          load_done_q, load_done_d;
    logic          nib_pending_q, nib_pending_d;
    logic          fetch_valid_q, fetch_valid_d;
`ifdef PROG_MEM_OPCODE_CHECK_EN
    logic          bad_op_q, bad_op_d;
`endif

    logic          mem_we;
    instr_word_t   mem_wdata;
    logic          rd_en;

    // Load FSM, write pointer and fetch handshake next-state logic
    always_comb begin
        state_d       = state_q;
        hi_d          = hi_q;
        wr_ptr_d      = wr_ptr_q;
        mem_we        = 1'b0;
        mem_wdata     = '0;
`ifdef PROG_MEM_OPCODE_CHECK_EN
        bad_op_d      = bad_op_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load_en && kbd_valid && !load_done_q) begin
                    hi_d    = kbd;
`ifdef PROG_MEM_OPCODE_CHECK_EN
                    if (!is_legal_op(kbd)) begin
                        hi_d     = OP_NOP;
                        bad_op_d = 1'b1;
                    end
`endif
                    state_d = ST_HI_HELD;
                end
            end
            ST_HI_HELD: begin
                // Without load_en the opcode nibble is simply held
                if (load_en && kbd_valid) begin
                    mem_we            = 1'b1;
                    mem_wdata.opcode  = hi_q;
                    mem_wdata.operand = kbd;
                    wr_ptr_d          = wr_ptr_q + AW'(1);
                    state_d           = (wr_ptr_q == AW'(DEPTH - 1)) ? ST_FULL : ST_IDLE;
                end
            end
            ST_FULL: begin
                state_d = ST_FULL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        load_done_d   = (state_d == ST_FULL);
        nib_pending_d = (state_d == ST_HI_HELD);
        // Load mode wins over a fetch request
        rd_en         = fetch_req && !load_en;
        fetch_valid_d = rd_en;
    end

    // State and output registers with synchronous clear
    always_ff @(posedge clk1) begin
        if (MainClear) begin
            state_q       <= ST_IDLE;
            hi_q          <= '0;
            wr_ptr_q      <= '0;
            load_done_q   <= 1'b0;
            nib_pending_q <= 1'b0;
            fetch_valid_q <= 1'b0;
`ifdef PROG_MEM_OPCODE_CHECK_EN
            bad_op_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            hi_q          <= hi_d;
            wr_ptr_q      <= wr_ptr_d;
            load_done_q   <= load_done_d;
            nib_pending_q <= nib_pending_d;
            fetch_valid_q <= fetch_valid_d;
`ifdef PROG_MEM_OPCODE_CHECK_EN
            bad_op_q      <= bad_op_d;
`endif
        end
    end

    prog_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_mem (
        .clk   (clk1),
        .clr   (MainClear),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (mem_wdata),
        .rd_en (rd_en),
        .raddr (fetch_addr),
        .rdata (instr)
    );

    assign fetch_valid = fetch_valid_q;
    assign wr_ptr      = wr_ptr_q;
    assign load_done   = load_done_q;
    assign nib_pending = nib_pending_q;
`ifdef PROG_MEM_OPCODE_CHECK_EN
    assign bad_op      = bad_op_q;
`endif

endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: fetch expectations are queued at issue
// time and matched by a monitor whenever fetch_valid is presented.
module tb_prog_mem_loader;

    logic       clk1 = 1'b0;
    logic       MainClear;
    logic       load_en;
    logic [3:0] kbd;
    logic       kbd_valid;
    logic       fetch_req;
    logic [2:0] fetch_addr;
    logic       fetch_valid;
    logic [7:0] instr;
    logic [2:0] wr_ptr;
    logic       load_done;
    logic       nib_pending;
`ifdef PROG_MEM_OPCODE_CHECK_EN
    logic       bad_op;
`endif

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] fill_w [8];

    prog_mem_loader dut (
        .clk1        (clk1),
        .MainClear   (MainClear),
        .load_en     (load_en),
        .kbd         (kbd),
        .kbd_valid   (kbd_valid),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .instr       (instr),
        .wr_ptr      (wr_ptr),
        .load_done   (load_done),
        .nib_pending (nib_pending)
`ifdef PROG_MEM_OPCODE_CHECK_EN
        ,
        .bad_op      (bad_op)
`endif
    );

    always #5 clk1 = ~clk1;

    // Monitor: every presented response must match the oldest queued fetch
    always @(negedge clk1) begin
        if (fetch_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_fetch_valid: got instr=%h, required no response", instr);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (instr !== e) begin
                    failures++;
                    $display("FAIL fetch_instr: got %h, required %h", instr, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        MainClear = 1'b1;
        kbd_valid = 1'b0;
        fetch_req = 1'b0;
        tick();
        MainClear = 1'b0;
    endtask

    task automatic nib(input logic [3:0] v);
        load_en   = 1'b1;
        fetch_req = 1'b0;
        kbd       = v;
        kbd_valid = 1'b1;
        tick();
        kbd_valid = 1'b0;
    endtask

    task automatic fetch(input logic [2:0] a, input logic [7:0] e);
        load_en    = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = a;
        exp_q.push_back(e);
        tick();
        fetch_req  = 1'b0;
    endtask

    initial begin
        fill_w[0] = 8'h10; fill_w[1] = 8'h21; fill_w[2] = 8'h32; fill_w[3] = 8'h43;
        fill_w[4] = 8'h54; fill_w[5] = 8'h05; fill_w[6] = 8'h16; fill_w[7] = 8'h27;
        MainClear  = 1'b1;
        load_en    = 1'b0;
        kbd        = 4'h0;
        kbd_valid  = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = 3'd0;
        tick();
        tick();
        MainClear = 1'b0;

        // Reset state
        chk("rst_wr_ptr", 8'(wr_ptr), 8'h00);
        chk("rst_load_done", 8'(load_done), 8'h00);
        chk("rst_nib_pending", 8'(nib_pending), 8'h00);
        chk("rst_fetch_valid", 8'(fetch_valid), 8'h00);
        chk("rst_instr", instr, 8'h00);

        // Fetch after reset returns NOP
        fetch(3'd3, 8'h00);
        tick();

        // Load two words, then back-to-back fetches
        nib(4'h1);
        chk("nib_pending_hi", 8'(nib_pending), 8'h01);
        nib(4'h5);
        chk("nib_pending_lo", 8'(nib_pending), 8'h00);
        nib(4'h2);
        nib(4'h3);
        chk("wr_ptr_two", 8'(wr_ptr), 8'h02);
        fetch(3'd0, 8'h15);
        fetch(3'd1, 8'h23);
        chk("b2b_latency_valid", 8'(fetch_valid), 8'h01);
        chk("b2b_latency_instr", instr, 8'h23);
        tick();
        chk("idle_fetch_valid", 8'(fetch_valid), 8'h00);
        chk("idle_instr_hold", instr, 8'h23);

        // Fill all eight words, then an extra nibble is ignored
        do_reset();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] w;
            w = fill_w[i];
            nib(w[7:4]);
            nib(w[3:0]);
            if (i == 6) chk("not_full_yet", 8'(load_done), 8'h00);
        end
        chk("full_load_done", 8'(load_done), 8'h01);
        chk("full_wr_ptr_wrap", 8'(wr_ptr), 8'h00);
        nib(4'h4);
        chk("full_ignore_pending", 8'(nib_pending), 8'h00);
        chk("full_stays", 8'(load_done), 8'h01);
        for (int i = 0; i < 8; i++) begin
            fetch(3'(i), fill_w[i]);
        end
        tick();

        // Fetch request in load mode is dropped; paused word resumes
        do_reset();
        load_en    = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 3'd0;
        tick();
        fetch_req  = 1'b0;
        chk("conflict_no_valid", 8'(fetch_valid), 8'h00);
        nib(4'h3);
        load_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            kbd       = 4'hF;
            kbd_valid = (i == 2);
            tick();
        end
        kbd_valid = 1'b0;
        chk("pause_pending_held", 8'(nib_pending), 8'h01);
        chk("pause_wr_ptr", 8'(wr_ptr), 8'h00);
        nib(4'h9);
        chk("resume_wr_ptr", 8'(wr_ptr), 8'h01);
        fetch(3'd0, 8'h39);
        fetch(3'd1, 8'h00);
        tick();

        // Reset mid-word discards the opcode nibble
        do_reset();
        nib(4'h4);
        do_reset();
        chk("midrst_pending", 8'(nib_pending), 8'h00);
        chk("midrst_wr_ptr", 8'(wr_ptr), 8'h00);
        nib(4'h1);
        nib(4'h2);
        fetch(3'd0, 8'h12);
        tick();

`ifdef PROG_MEM_OPCODE_CHECK_EN
        // Illegal opcode is stored as NOP and flagged until reset
        do_reset();
        chk("bad_op_rst", 8'(bad_op), 8'h00);
        nib(4'hA);
        chk("bad_op_set", 8'(bad_op), 8'h01);
        nib(4'h7);
        fetch(3'd0, 8'h07);
        tick();
        tick();
        chk("bad_op_sticky", 8'(bad_op), 8'h01);
        do_reset();
        chk("bad_op_cleared", 8'(bad_op), 8'h00);
`endif

        // All queued fetches must have been answered
        repeat (4) tick();
        chk("queue_drained", 8'(exp_q.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
